// File: rtl/atto_pkg.sv
// Shared definitions for the second-generation atto microcore: opcodes, ALU functions,
// FSM states and register alias indices.
package atto_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd1;
    localparam logic [2:0] OP_ALU   = 3'd2;
    localparam logic [2:0] OP_LDI   = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;
    localparam logic [2:0] OP_WRITE = 3'd5;
    localparam logic [2:0] OP_COPY  = 3'd6;
    localparam logic [2:0] OP_SYS   = 3'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    typedef enum logic [2:0] {FETCH, EXEC, IMM, MEM, HALTED} state_e;

    localparam int unsigned R_ADDR_LO = 0;
    localparam int unsigned R_ADDR_HI = 1;
    localparam int unsigned R_PC_LO   = 2;
    localparam int unsigned R_PC_HI   = 3;
    localparam int unsigned R_IR      = 4;
    localparam int unsigned R_ALU_A   = 5;
    localparam int unsigned R_ALU_B   = 6;
    localparam int unsigned R_ALU_Y   = 7;

endpackage

// File: rtl/atto_alu_p.sv
// Combinational 8-function ALU; fn[3] forces a zero result.
module atto_alu_p
    import atto_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [3:0]    fn,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    always_comb begin
        y = '0;
        if (!fn[3]) begin
            unique case (fn[2:0])
                ALU_ADD: y = a + b;
                ALU_SUB: y = a - b;
                ALU_AND: y = a & b;
                ALU_OR:  y = a | b;
                ALU_XOR: y = a ^ b;
                ALU_NOT: y = ~a;
                ALU_SHL: y = {a[DW-2:0], 1'b0};
                ALU_SHR: y = {1'b0, a[DW-1:1]};
                default: y = '0;
            endcase
        end
    end

endmodule

// File: rtl/atto_core_p.sv
// Atto microcore top: FSM, register file and handshaked memory bus driver.
module atto_core_p
    import atto_pkg::*;
#(
    parameter  int unsigned DW   = 8,
    parameter  int unsigned NREG = 16,
    localparam int unsigned AW   = 2 * DW
) (
    input  logic          clock,
    input  logic          reset,
    output logic [AW-1:0] address_bus,
    output logic [DW-1:0] data_out,
    input  logic [DW-1:0] data_in,
    output logic          data_dir,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          halted
);

    localparam int unsigned RI = $clog2(NREG);

    state_e        state_q, state_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    logic [DW-1:0] ir;
    logic [2:0]    op;
    logic [RI-1:0] n, cp_dst, cp_src;
    logic [AW-1:0] pc, pc_inc, addr;
    logic [DW-1:0] alu_y;
    logic          xfer;

    assign ir     = regs_q[R_IR];
    assign op     = ir[7:5];
    assign n      = ir[RI-1:0];
    assign cp_dst = data_in[4 +: RI];
    assign cp_src = data_in[RI-1:0];
    assign pc     = {regs_q[R_PC_HI], regs_q[R_PC_LO]};
    assign addr   = {regs_q[R_ADDR_HI], regs_q[R_ADDR_LO]};
    assign pc_inc = pc + AW'(1);
    assign xfer   = mem_valid & mem_ready;

    atto_alu_p #(
        .DW (DW)
    ) u_alu (
        .fn (ir[3:0]),
        .a  (regs_q[R_ALU_A]),
        .b  (regs_q[R_ALU_B]),
        .y  (alu_y)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: if (xfer) state_d = EXEC;
            EXEC: begin
                unique case (op)
                    OP_LDI, OP_COPY:   state_d = IMM;
                    OP_READ, OP_WRITE: state_d = MEM;
                    OP_SYS:            state_d = ir[4] ? HALTED : FETCH;
                    default:           state_d = FETCH;
                endcase
            end
            IMM, MEM: if (xfer) state_d = FETCH;
            HALTED:   state_d = HALTED;
            default:  state_d = FETCH;
        endcase
    end

    // Outputs are gated by reset so an in-flight request drops without waiting for a clock.
    always_comb begin
        mem_valid   = 1'b0;
        data_dir    = 1'b1;
        data_out    = '0;
        address_bus = pc;
        halted      = 1'b0;
        unique case (state_q)
            FETCH, IMM: mem_valid = reset;
            MEM: begin
                mem_valid   = reset;
                address_bus = addr;
                if (op == OP_WRITE) begin
                    data_dir = ~reset;
                    data_out = regs_q[n];
                end
            end
            HALTED:  halted = 1'b1;
            default: ;
        endcase
    end

    // PC update is applied first so a same-edge destination write to r2/r3 wins.
    always_comb begin
        regs_d = regs_q;
        unique case (state_q)
            FETCH: begin
                if (xfer) begin
                    regs_d[R_PC_LO] = pc_inc[DW-1:0];
                    regs_d[R_PC_HI] = pc_inc[AW-1:DW];
                    regs_d[R_IR]    = DW'(data_in[7:0]);
                end
            end
            EXEC: begin
                unique case (op)
                    OP_JUMP: begin
                        regs_d[R_PC_LO] = addr[DW-1:0];
                        regs_d[R_PC_HI] = addr[AW-1:DW];
                    end
                    OP_ALU: regs_d[R_ALU_Y] = alu_y;
                    OP_SYS: begin
                        if (!ir[4] && (regs_q[n] == '0)) begin
                            regs_d[R_PC_LO] = addr[DW-1:0];
                            regs_d[R_PC_HI] = addr[AW-1:DW];
                        end
                    end
                    default: ;
                endcase
            end
            IMM: begin
                if (xfer) begin
                    regs_d[R_PC_LO] = pc_inc[DW-1:0];
                    regs_d[R_PC_HI] = pc_inc[AW-1:DW];
                    if (op == OP_LDI) begin
                        regs_d[n] = data_in;
                    end else begin
                        regs_d[cp_dst] = regs_q[cp_src];
                    end
                end
            end
            MEM: begin
                if (xfer && (op == OP_READ)) regs_d[n] = data_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule
